// File: rtl/ascon_round_sequencer_dom_pkg.sv
// Shared types and constants for the DOM-protected ASCON round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ascon_dom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Command codes understood by the sibling round-constant register.
  typedef enum logic [1:0] {
    RC_CLEAR = 2'b00,
    RC_INC_A = 2'b01,
    RC_INC_B = 2'b10,
    RC_LOAD  = 2'b11
  } rcmode_e;

  localparam logic [3:0] RC_PA_START  = 4'h0;
  localparam logic [3:0] RC_PB6_START = 4'h6;
  localparam logic [3:0] RC_PB8_START = 4'h4;
  localparam logic [3:0] RC_LAST      = 4'hB;

  // All permutations end on constant index B, so the start index fixes the round count.
  function automatic logic [3:0] start_index(input logic mode, input int pb_rounds);
    if (!mode) return RC_PA_START;
    return (pb_rounds == 8) ? RC_PB8_START : RC_PB6_START;
  endfunction

endpackage

// File: rtl/ascon_round_sequencer_dom_if.sv
// Handshake and datapath-strobe bundle between a controller and the round sequencer.
// Latency: n/a (wires only).
// Backpressure: start_i is only taken while ready_o is high; no other flow control.
// Ports: start_i/mode_i/abort_i (requests), ready_o/busy_o/done_o (status),
//        rcmode_o/constti_o (constant register), rnd_req_o/sbox_en_o/state_en_o/
//        round_idx_o/last_round_o (datapath strobes).
interface ascon_round_sequencer_dom_if;
  import ascon_dom_pkg::*;

  logic       start_i;
  logic       mode_i;
  logic       abort_i;
  logic       ready_o;
  logic       busy_o;
  rcmode_e    rcmode_o;
  logic [3:0] constti_o;
  logic       rnd_req_o;
  logic       sbox_en_o;
  logic       state_en_o;
  logic [3:0] round_idx_o;
  logic       last_round_o;
  logic       done_o;

  modport master (
    output start_i, mode_i, abort_i,
    input  ready_o, busy_o, rcmode_o, constti_o, rnd_req_o, sbox_en_o,
           state_en_o, round_idx_o, last_round_o, done_o
  );

  modport slave (
    input  start_i, mode_i, abort_i,
    output ready_o, busy_o, rcmode_o, constti_o, rnd_req_o, sbox_en_o,
           state_en_o, round_idx_o, last_round_o, done_o
  );

endinterface

// File: rtl/ascon_round_sequencer_dom_phase_ctr.sv
// Round phase counter: counts 0..ROUND_CYCLES-1 while run is high, flags first/last phase.
// Latency: first/last are combinational from the registered phase.
// Backpressure: none; dropping run returns the counter to phase 0 on the next edge.
// Ports: clk, nRST (sync, active low), run (count enable, else clear), first, last.
module ascon_round_phase_ctr #(
  parameter int ROUND_CYCLES = 2
) (
  input  logic clk,
  input  logic nRST,
  input  logic run,
  output logic first,
  output logic last
);

  localparam int              PW         = $clog2(ROUND_CYCLES + 1);
  localparam logic [PW-1:0]   LAST_PHASE = PW'(ROUND_CYCLES - 1);

  logic [PW-1:0] phase;

  assign first = (phase == '0);
  assign last  = (phase == LAST_PHASE);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      phase <= '0;
    end else if (!run) begin
      phase <= '0;
    end else if (last) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/ascon_round_sequencer_dom.sv
// Sequences one DOM-protected ASCON permutation (p^a 12 rounds, p^b 6/8 rounds) and drives
// the round-constant register plus S-box / mask / state-write strobes.
// Latency: done_o 2+N*ROUND_CYCLES cycles after accept; start_i only taken in IDLE (ready_o).
// Ports: clk, nRST (sync, active low), bus (slave side of ascon_round_sequencer_dom_if).
module ascon_round_sequencer_dom
  import ascon_dom_pkg::*;
#(
  parameter int ROUND_CYCLES = 2,
  parameter int PB_ROUNDS    = 6
) (
  input logic                          clk,
  input logic                          nRST,
  ascon_round_sequencer_dom_if.slave   bus
);

  if (PB_ROUNDS != 6 && PB_ROUNDS != 8) begin : g_bad_pb_rounds
    $error("ascon_round_sequencer_dom: PB_ROUNDS must be 6 or 8");
  end
  if (ROUND_CYCLES < 1) begin : g_bad_round_cycles
    $error("ascon_round_sequencer_dom: ROUND_CYCLES must be at least 1");
  end

  seq_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       phase_first, phase_last;
  logic       phase_run;

  // Phase restarts at 0 whenever a round sequence is not actively running.
  assign phase_run = (state_q == ROUND) && !bus.abort_i;

  ascon_round_phase_ctr #(
    .ROUND_CYCLES (ROUND_CYCLES)
  ) u_phase (
    .clk   (clk),
    .nRST  (nRST),
    .run   (phase_run),
    .first (phase_first),
    .last  (phase_last)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.busy_o      = (state_q == LOAD) || (state_q == ROUND);
  assign bus.round_idx_o = idx_q;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    bus.rcmode_o     = RC_CLEAR;
    bus.constti_o    = 4'h0;
    bus.rnd_req_o    = 1'b0;
    bus.sbox_en_o    = 1'b0;
    bus.state_en_o   = 1'b0;
    bus.last_round_o = 1'b0;
    bus.done_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          state_d = LOAD;
          idx_d   = start_index(bus.mode_i, PB_ROUNDS);
        end
      end
      LOAD: begin
        bus.rcmode_o  = RC_LOAD;
        bus.constti_o = idx_q;
        state_d       = ROUND;
      end
      ROUND: begin
        bus.rnd_req_o    = phase_first;
        bus.sbox_en_o    = phase_first;
        bus.state_en_o   = phase_last;
        bus.last_round_o = (idx_q == RC_LAST);
        if (!phase_last) begin
          // The constant register has no hold code: reload the mirrored index.
          bus.rcmode_o  = RC_LOAD;
          bus.constti_o = idx_q;
        end else if (idx_q != RC_LAST) begin
          bus.rcmode_o = RC_INC_A;
          idx_d        = idx_q + 4'd1;
        end else begin
          // Clear the register so it sits at 0 again once the run ends.
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Abort wins over everything outside IDLE: clear the constant and drop all strobes.
    if (bus.abort_i && (state_q != IDLE)) begin
      state_d          = IDLE;
      idx_d            = '0;
      bus.rcmode_o     = RC_CLEAR;
      bus.constti_o    = 4'h0;
      bus.rnd_req_o    = 1'b0;
      bus.sbox_en_o    = 1'b0;
      bus.state_en_o   = 1'b0;
      bus.last_round_o = 1'b0;
      bus.done_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_ascon_round_sequencer_dom.sv
`timescale 1ns/1ps
module tb_ascon_round_sequencer_dom;
  import ascon_dom_pkg::*;

  localparam int NDUT = 3;

  // dut0: RC=2/PB=6, dut1: RC=2/PB=8, dut2: RC=1/PB=6
  function automatic int rcy_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction
  function automatic int pbr_of(input int g);
    return (g == 1) ? 8 : 6;
  endfunction

  localparam logic [31:0] NONE = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        nrst  [NDUT];
  logic        start [NDUT];
  logic        mode  [NDUT];
  logic        abort [NDUT];
  logic [16:0] obs   [NDUT];
  logic [3:0]  creg  [NDUT];

  logic [7:0]  exp_ct   [NDUT][$];
  int          exp_done [NDUT][$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int g, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got %0h want %0h", tag, g, cyc, got, want);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : u
    ascon_round_sequencer_dom_if bus ();
    logic [3:0] cnt;

    ascon_round_sequencer_dom #(
      .ROUND_CYCLES (rcy_of(g)),
      .PB_ROUNDS    (pbr_of(g))
    ) dut (
      .clk  (clk),
      .nRST (nrst[g]),
      .bus  (bus.slave)
    );

    assign bus.start_i = start[g];
    assign bus.mode_i  = mode[g];
    assign bus.abort_i = abort[g];
    assign obs[g] = {bus.ready_o, bus.busy_o, bus.rcmode_o, bus.constti_o, bus.rnd_req_o,
                     bus.sbox_en_o, bus.state_en_o, bus.round_idx_o, bus.last_round_o, bus.done_o};
    assign creg[g] = cnt;

    // Behavioural round-constant register (sibling block): index in, {~i,i} constant out.
    always @(posedge clk) begin
      if (!nrst[g]) cnt <= 4'h0;
      else begin
        case (bus.rcmode_o)
          RC_CLEAR: cnt <= 4'h0;
          RC_LOAD:  cnt <= bus.constti_o;
          default:  cnt <= cnt + 4'h1;
        endcase
      end
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
      if (nrst[g] === 1'b1) begin
        if (bus.sbox_en_o && !bus.state_en_o && exp_ct[g].size() > 0)
          check("constt_hold", g, 32'({~cnt, cnt}), 32'(exp_ct[g][0]));
        if (bus.state_en_o) begin
          check("constt", g, 32'({~cnt, cnt}),
                (exp_ct[g].size() == 0) ? NONE : 32'(exp_ct[g].pop_front()));
          check("round_idx", g, 32'(bus.round_idx_o), 32'(cnt));
          check("last_round", g, 32'(bus.last_round_o), 32'(cnt == 4'hB));
          check("rnd_req_phase", g, 32'(bus.rnd_req_o), 32'(rcy_of(g) == 1));
        end
        if (bus.done_o)
          check("done_cycle", g, 32'(cyc),
                (exp_done[g].size() == 0) ? NONE : 32'(exp_done[g].pop_front()));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int g, input logic m, input int c0);
    int n;
    logic [3:0] i;
    n = m ? pbr_of(g) : 12;
    for (int r = 0; r < n; r++) begin
      i = 4'(12 - n + r);
      exp_ct[g].push_back({~i, i});
    end
    exp_done[g].push_back(c0 + 2 + n * rcy_of(g));
  endtask

  task automatic launch(input int g, input logic m);
    push_run(g, m, cyc);
    start[g] = 1'b1;
    mode[g]  = m;
    tick();
    start[g] = 1'b0;
    mode[g]  = 1'b0;
  endtask

  task automatic flush(input int g);
    exp_ct[g].delete();
    exp_done[g].delete();
  endtask

  task automatic expect_idle(input string tag, input int g);
    check(tag, g, 32'(obs[g][16:15]), 32'b10);
    check({tag, "_creg"}, g, 32'(creg[g]), 32'h0);
  endtask

  initial begin
    int c;
    for (int g = 0; g < NDUT; g++) begin
      nrst[g] = 1'b0; start[g] = 1'b0; mode[g] = 1'b0; abort[g] = 1'b0;
    end
    tick(2);
    for (int g = 0; g < NDUT; g++) begin
      check("reset_outputs", g, 32'(obs[g]), 32'h10000);
      nrst[g] = 1'b1;
    end

    // Plain runs on every configuration.
    launch(0, 1'b0); tick(30); expect_idle("after_pa", 0);
    launch(0, 1'b1); tick(16);
    launch(1, 1'b1); tick(20);
    launch(1, 1'b0); tick(28);
    launch(2, 1'b0); tick(16);
    launch(2, 1'b1); tick(10); expect_idle("after_pb_rc1", 2);

    // Abort in phase 0 of round index 5.
    c = cyc;
    launch(0, 1'b0);
    tick(c + 12 - cyc);
    abort[0] = 1'b1;
    @(negedge clk);
    check("abort_rcmode", 0, 32'(obs[0][14:13]), 32'h0);
    tick();
    abort[0] = 1'b0;
    flush(0);
    expect_idle("after_abort", 0);
    tick(20);

    // Reset for one cycle mid-run, then a fresh run.
    launch(0, 1'b1);
    tick(5);
    nrst[0] = 1'b0;
    flush(0);
    tick();
    check("midrun_reset", 0, 32'(obs[0]), 32'h10000);
    check("midrun_reset_creg", 0, 32'(creg[0]), 32'h0);
    nrst[0] = 1'b1;
    tick(3);
    launch(0, 1'b1); tick(16);

    // Abort together with start in IDLE must not be accepted.
    start[0] = 1'b1; abort[0] = 1'b1;
    tick();
    start[0] = 1'b0; abort[0] = 1'b0;
    check("abort_start_idle", 0, 32'(obs[0][16:15]), 32'b10);
    tick(5);

    // start_i held high: second run only accepted after DONE, in IDLE.
    c = cyc;
    push_run(0, 1'b0, c);
    push_run(0, 1'b0, c + 27);
    start[0] = 1'b1;
    tick(28);
    start[0] = 1'b0;
    tick(32);

    for (int g = 0; g < NDUT; g++) begin
      check("pending_constt", g, 32'(exp_ct[g].size()), 32'h0);
      check("pending_done", g, 32'(exp_done[g].size()), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
